sync_axis_fifo: RTL

Single-clock AXI-Stream FIFO. It is the parametrised successor to the team's dual-clock stream FIFO, for paths where producer and consumer share one clock. It adds the following over that FIFO:
- non-power-of-two depth
- a fill count
- programmable almost-full and almost-empty flags
- synchronous flush
- optional packet mode, in which output is held until a complete packet (tlast) is stored

It sits between stream sources and sinks inside one clock domain.

---
 rtl/sync_axis_fifo_pkg.sv | 28 ++
 rtl/sync_axis_fifo_mem.sv | 28 ++
 rtl/sync_axis_fifo.sv | 132 +++++++++++++
 3 files changed

// File: rtl/sync_axis_fifo_pkg.sv
// Shared helpers for the single-clock stream FIFO: widths and parameter sanity.
// No logic, no latency.
// No flow control; elaboration-time helpers only.
package sync_axis_fifo_pkg;

    // Fill counter must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // A stored entry is the payload plus its end-of-packet marker.
    function automatic int entry_width(input int data_width);
        return data_width + 1;
    endfunction

    function automatic bit depth_ok(input int depth);
        return depth >= 2;
    endfunction

    function automatic bit af_thresh_ok(input int depth, input int af_thresh);
        return (af_thresh >= 1) && (af_thresh <= depth);
    endfunction

    function automatic bit ae_thresh_ok(input int depth, input int ae_thresh);
        return (ae_thresh >= 0) && (ae_thresh <= depth - 1);
    endfunction

endpackage

// File: rtl/sync_axis_fifo_mem.sv
// Register-array storage for the stream FIFO, one write port, one read port.
// Write lands on the clock edge; read is combinational from the address.
// No flow control; the owner decides when wr_en is allowed.
module fifo_mem #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 9,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_dat
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately unreset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/sync_axis_fifo.sv
// Single-clock AXI-Stream FIFO with fill count, almost flags, flush and packet mode.
// First-word-fall-through: a word written at edge N is offered from cycle N+1.
// s_axis_ready drops when full (no write-through); m_axis_valid may wait for a whole packet.
module sync_axis_fifo
    import sync_axis_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 128,
    parameter int AF_THRESH   = DEPTH - 2,
    parameter int AE_THRESH   = 2,
    parameter bit PACKET_MODE = 1'b0,
    parameter int CNT_W       = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic                  s_axis_last,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_last,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic [CNT_W-1:0]      fill_count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = entry_width(DATA_WIDTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } entry_t;

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("sync_axis_fifo: DEPTH must be at least 2");
    end
    if (!af_thresh_ok(DEPTH, AF_THRESH)) begin : g_bad_af
        $error("sync_axis_fifo: AF_THRESH must lie in 1..DEPTH");
    end
    if (!ae_thresh_ok(DEPTH, AE_THRESH)) begin : g_bad_ae
        $error("sync_axis_fifo: AE_THRESH must lie in 0..DEPTH-1");
    end

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W-1:0] pkt_count;
    logic [CNT_W-1:0] pkt_count_nxt;
    logic             wr_fire;
    logic             rd_fire;
    entry_t           wr_entry;
    entry_t           rd_entry;

    assign wr_entry = '{data: s_axis_data, last: s_axis_last};

    fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_fire),
        .wr_addr (wr_ptr),
        .wr_dat  (wr_entry),
        .rd_addr (rd_ptr),
        .rd_dat  (rd_entry)
    );

    // Ready ignores the consumer side, so a full FIFO never accepts even while draining.
    assign s_axis_ready = reset_n && !flush && !full;

    // In packet mode the full term releases an over-long packet that could never complete.
    assign m_axis_valid = !flush && !empty && (!PACKET_MODE || (pkt_count != '0) || full);
    assign m_axis_data  = rd_entry.data;
    assign m_axis_last  = rd_entry.last;

    assign wr_fire = s_axis_valid && s_axis_ready;
    assign rd_fire = m_axis_valid && m_axis_ready;

    assign fill_count = count;

    // Next fill level and stored-packet tally; simultaneous in/out leaves them unchanged.
    always_comb begin
        count_nxt     = count;
        pkt_count_nxt = pkt_count;
        if (wr_fire && !rd_fire) begin
            count_nxt = count + CNT_W'(1);
        end else if (rd_fire && !wr_fire) begin
            count_nxt = count - CNT_W'(1);
        end
        if ((wr_fire && s_axis_last) && !(rd_fire && rd_entry.last)) begin
            pkt_count_nxt = pkt_count + CNT_W'(1);
        end else if ((rd_fire && rd_entry.last) && !(wr_fire && s_axis_last)) begin
            pkt_count_nxt = pkt_count - CNT_W'(1);
        end
    end

    // Pointers, counters and registered status; reset beats flush beats transfers.
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            pkt_count    <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (wr_fire) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (rd_fire) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            count        <= count_nxt;
            pkt_count    <= pkt_count_nxt;
            full         <= (count_nxt == CNT_W'(DEPTH));
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= CNT_W'(AF_THRESH));
            almost_empty <= (count_nxt <= CNT_W'(AE_THRESH));
        end
    end

endmodule
